fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch sequencer that drives the control unit's instruction handshake. It reads the word at the current PC from instruction memory and presents it on MEM_INST with a one-cycle INST_ENB pulse. It then waits for the control unit's PC_CLK rising edge, which marks the PC update, before fetching the next word. It sits between the PC register, instruction memory and cu, and also flags misaligned or timed-out fetches.

## Interface
- TIMEOUT_CYC, 16: maximum cycles MEM_REQ is held without MEM_ACK before a fetch error (≥2).
- NOP_INST, 32'h0000_0013: reset/idle value of MEM_INST (addi x0,x0,0).
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- PC_ADDR  in  32  current program counter from the PC register.
- PC_CLK  in  1  from cu; low while an instruction is being dispatched, a rising edge means the PC has been advanced.
- STALL  in  1  when high, no new fetch starts (sampled only in IDLE).
- MEM_ADR  out  32  instruction memory word address.
- MEM_REQ  out  1  read request; held until MEM_ACK or timeout.
- MEM_RDATA  in  32  instruction memory read data, valid when MEM_ACK=1.
- MEM_ACK  in  1  read data valid.
- MEM_INST  out  32  fetched instruction to cu; stable from INST_ENB until the next INST_ENB.
- INST_ENB  out  1  one-cycle pulse: MEM_INST is new and valid.
- FETCH_ERR  out  1  sticky error flag (misaligned PC or memory timeout).
- BUSY  out  1  high in every state except IDLE and ERROR.
- FETCH_CNT  out  32  count of issued instructions; wraps at 2^32 to 0.

## Operation
- Reset values (next edge with RST=1, from any state): state IDLE, MEM_ADR=0, MEM_REQ=0, MEM_INST=NOP_INST, INST_ENB=0, FETCH_ERR=0, BUSY=0, FETCH_CNT=0, timeout counter=0, registered pc_clk_q=0.
- The FSM has six states: IDLE, WAIT_MEM, ISSUE, WAIT_CU, SETTLE, ERROR.
- **IDLE**
  - If PC_CLK=1 and STALL=0 and PC_ADDR[1:0]≠0: FETCH_ERR←1, go to ERROR. No request is issued.
  - If PC_CLK=1 and STALL=0 and PC_ADDR aligned: MEM_ADR←PC_ADDR, MEM_REQ←1, counter←0, go to WAIT_MEM.
  - Otherwise stay in IDLE.
- **WAIT_MEM**
  - If MEM_ACK=1: MEM_INST←MEM_RDATA, MEM_REQ←0, INST_ENB←1, go to ISSUE.
  - Else if counter=TIMEOUT_CYC−1: MEM_REQ←0, FETCH_ERR←1, go to ERROR.
  - Otherwise counter+1.
  - MEM_ACK on the timeout cycle wins: the fetch completes and no error is raised.
- **ISSUE** (exactly one cycle): INST_ENB←0, FETCH_CNT←FETCH_CNT+1, go to WAIT_CU.
- **WAIT_CU**: stay until a rising edge of PC_CLK (pc_clk_q=0 and PC_CLK=1), then go to SETTLE. PC_CLK held high without a low phase does not advance the FSM.
- **SETTLE** (one cycle): gives the PC register time to update, then go to IDLE.
- **ERROR**: all outputs frozen, MEM_REQ=0, FETCH_ERR=1. Only RST leaves this state.
- MEM_ACK is ignored outside WAIT_MEM. STALL is ignored outside IDLE, so an in-flight fetch always completes.
- pc_clk_q←PC_CLK every cycle, in all states.

## Timing
- Fetch latency with zero-wait memory (MEM_ACK high in the first MEM_REQ cycle):
  - Edge 0: IDLE accepts.
  - Edge 1: data latched, INST_ENB goes high.
  - Edge 2: INST_ENB low.
  - That is 1 cycle of MEM_REQ and 1 cycle of INST_ENB.
- With N wait cycles, MEM_REQ stays high for N+1 cycles and INST_ENB rises the edge after MEM_ACK.
- Next-fetch turnaround: PC_CLK rise sampled at edge k gives SETTLE after k, IDLE after k+1, and MEM_REQ high after k+2 (if STALL=0).
- Timeout: MEM_REQ is high for exactly TIMEOUT_CYC cycles, then FETCH_ERR rises on the same edge that MEM_REQ falls.
- MEM_ADR changes only on the IDLE→WAIT_MEM edge.
- RST mid-fetch: MEM_REQ drops on the RST edge and no INST_ENB is produced. A late MEM_ACK after reset is ignored.
- FETCH_CNT increments on the edge that ends ISSUE (0xFFFF_FFFF→0x0000_0000).

## Test plan
- Reset then PC_CLK=1, PC_ADDR=0x0, zero-wait memory returning 0x00500093 -> MEM_REQ 1 cycle with MEM_ADR=0x0, then MEM_INST=0x00500093 with INST_ENB 1 cycle, FETCH_CNT=1.
- Three sequential fetches with the cu model toggling PC_CLK low/high and PC_ADDR 0x0/0x4/0x8 -> three INST_ENB pulses with matching MEM_ADR and MEM_INST; no request issued before SETTLE completes.
- Memory with 3 wait cycles -> MEM_REQ high 4 cycles; MEM_ACK with TIMEOUT_CYC=4 arriving on the 4th cycle -> data accepted, FETCH_ERR=0.
- No MEM_ACK, TIMEOUT_CYC=16 -> MEM_REQ high exactly 16 cycles, then FETCH_ERR=1 and BUSY=0. PC_CLK toggling afterward causes no request; RST clears all outputs.
- PC_ADDR=0x6 in IDLE with PC_CLK=1 -> no MEM_REQ, FETCH_ERR=1 on the next edge. STALL=1 in IDLE -> no request until STALL drops. STALL asserted during WAIT_MEM -> fetch still completes.
- RST asserted during WAIT_MEM with MEM_ACK arriving the next cycle -> MEM_REQ=0, no INST_ENB, MEM_INST=0x00000013, FETCH_CNT=0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer between PC register, instruction memory and cu.
module fetch_unit #(
  parameter int          TIMEOUT_CYC = 16,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] PC_ADDR,
  input  logic        PC_CLK,
  input  logic        STALL,
  output logic [31:0] MEM_ADR,
  output logic        MEM_REQ,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_ACK,
  output logic [31:0] MEM_INST,
  output logic        INST_ENB,
  output logic        FETCH_ERR,
  output logic        BUSY,
  output logic [31:0] FETCH_CNT
);
  localparam int CW = $clog2(TIMEOUT_CYC);
  typedef enum logic [2:0] {IDLE, WAIT_MEM, ISSUE, WAIT_CU, SETTLE, ERROR} state_t;
  state_t state_q, state_d;
  logic [31:0] mem_adr_q, mem_adr_d, mem_inst_q, mem_inst_d, fetch_cnt_q, fetch_cnt_d;
  logic mem_req_q, mem_req_d, inst_enb_q, inst_enb_d, fetch_err_q, fetch_err_d, pc_clk_q;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    state_d     = state_q;
    mem_adr_d   = mem_adr_q;
    mem_req_d   = mem_req_q;
    mem_inst_d  = mem_inst_q;
    inst_enb_d  = inst_enb_q;
    fetch_err_d = fetch_err_q;
    fetch_cnt_d = fetch_cnt_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: if (PC_CLK && !STALL) begin
        if (PC_ADDR[1:0] != 2'b00) begin
          fetch_err_d = 1'b1;
          state_d     = ERROR;
        end else begin
          mem_adr_d = PC_ADDR;
          mem_req_d = 1'b1;
          cnt_d     = '0;
          state_d   = WAIT_MEM;
        end
      end
      // an ack on the final timeout cycle still completes the fetch
      WAIT_MEM: if (MEM_ACK) begin
        mem_inst_d = MEM_RDATA;
        mem_req_d  = 1'b0;
        inst_enb_d = 1'b1;
        state_d    = ISSUE;
      end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
        mem_req_d   = 1'b0;
        fetch_err_d = 1'b1;
        state_d     = ERROR;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      ISSUE: begin
        inst_enb_d  = 1'b0;
        fetch_cnt_d = fetch_cnt_q + 32'd1;
        state_d     = WAIT_CU;
      end
      WAIT_CU: state_d = (!pc_clk_q && PC_CLK) ? SETTLE : WAIT_CU;
      SETTLE:  state_d = IDLE;
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      mem_adr_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_inst_q  <= NOP_INST;
      inst_enb_q  <= 1'b0;
      fetch_err_q <= 1'b0;
      fetch_cnt_q <= '0;
      cnt_q       <= '0;
      pc_clk_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_adr_q   <= mem_adr_d;
      mem_req_q   <= mem_req_d;
      mem_inst_q  <= mem_inst_d;
      inst_enb_q  <= inst_enb_d;
      fetch_err_q <= fetch_err_d;
      fetch_cnt_q <= fetch_cnt_d;
      cnt_q       <= cnt_d;
      pc_clk_q    <= PC_CLK;
    end
  end
  assign MEM_ADR   = mem_adr_q;
  assign MEM_REQ   = mem_req_q;
  assign MEM_INST  = mem_inst_q;
  assign INST_ENB  = inst_enb_q;
  assign FETCH_ERR = fetch_err_q;
  assign FETCH_CNT = fetch_cnt_q;
  assign BUSY      = (state_q != IDLE) && (state_q != ERROR);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch/handshake traffic checked against a transaction-level model.
module tb_fetch_unit;
  localparam int TO = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic CLK = 1'b0, RST = 1'b1, PC_CLK = 1'b0, STALL = 1'b0, MEM_ACK = 1'b0;
  logic [31:0] PC_ADDR = '0, MEM_RDATA = '0;
  logic [31:0] MEM_ADR, MEM_INST, FETCH_CNT;
  logic MEM_REQ, INST_ENB, FETCH_ERR, BUSY;
  logic [31:0] mem [256];
  logic [31:0] cnt, last_adr;
  int n_cmp = 0, n_bad = 0;

  fetch_unit #(.TIMEOUT_CYC(TO), .NOP_INST(NOP)) dut (
    .CLK(CLK), .RST(RST), .PC_ADDR(PC_ADDR), .PC_CLK(PC_CLK), .STALL(STALL),
    .MEM_ADR(MEM_ADR), .MEM_REQ(MEM_REQ), .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK),
    .MEM_INST(MEM_INST), .INST_ENB(INST_ENB), .FETCH_ERR(FETCH_ERR), .BUSY(BUSY),
    .FETCH_CNT(FETCH_CNT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RST = 1'b1; PC_CLK = 1'b0; STALL = 1'b0; MEM_ACK = 1'b0;
    tick;
    chk("rst_req", 32'(MEM_REQ), 32'd0);
    chk("rst_adr", MEM_ADR, 32'd0);
    chk("rst_inst", MEM_INST, NOP);
    chk("rst_enb", 32'(INST_ENB), 32'd0);
    chk("rst_err", 32'(FETCH_ERR), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_cnt", FETCH_CNT, 32'd0);
    RST = 1'b0;
    cnt = 0;
  endtask

  // one fetch from IDLE: memory answers after w wait cycles
  task automatic fetch(input logic [31:0] a, input int w, input bit smid);
    int n;
    logic [31:0] d;
    d = mem[a[9:2]];
    PC_ADDR = a; PC_CLK = 1'b1; STALL = 1'b0;
    tick;
    chk("req_on", 32'(MEM_REQ), 32'd1);
    chk("adr", MEM_ADR, a);
    chk("busy_mem", 32'(BUSY), 32'd1);
    n = 0;
    while (MEM_REQ && n <= TO) begin
      MEM_ACK = (n == w);
      MEM_RDATA = (n == w) ? d : $urandom;
      STALL = smid;
      tick;
      n++;
    end
    MEM_ACK = 1'b0; STALL = 1'b0; MEM_RDATA = $urandom;
    chk("req_cycles", 32'(n), 32'(w + 1));
    chk("enb_on", 32'(INST_ENB), 32'd1);
    chk("inst", MEM_INST, d);
    chk("no_err", 32'(FETCH_ERR), 32'd0);
    chk("cnt_pre", FETCH_CNT, cnt);
    tick;
    cnt++;
    last_adr = a;
    chk("enb_off", 32'(INST_ENB), 32'd0);
    chk("cnt", FETCH_CNT, cnt);
    chk("inst_hold", MEM_INST, d);
  endtask

  // cu: hold PC_CLK high, then low phase, then rising edge with new PC
  task automatic cu_step(input logic [31:0] nxt);
    repeat ($urandom_range(0, 3)) begin
      tick;
      chk("wcu_busy", 32'(BUSY), 32'd1);
      chk("wcu_req", 32'(MEM_REQ), 32'd0);
    end
    PC_CLK = 1'b0;
    repeat ($urandom_range(1, 3)) tick;
    chk("wcu_low_busy", 32'(BUSY), 32'd1);
    PC_CLK = 1'b1; PC_ADDR = nxt;
    tick;
    chk("settle_req", 32'(MEM_REQ), 32'd0);
    chk("settle_busy", 32'(BUSY), 32'd1);
    chk("adr_hold", MEM_ADR, last_adr);
    tick;
    chk("idle_req", 32'(MEM_REQ), 32'd0);
    chk("idle_busy", 32'(BUSY), 32'd0);
  endtask

  initial begin
    int n, w;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h0050_0093;
    do_reset;
    fetch(32'h0, 0, 1'b0);
    cu_step(32'h4);
    fetch(32'h4, 0, 1'b0);
    cu_step(32'h8);
    fetch(32'h8, 3, 1'b0);
    cu_step(32'hC);
    fetch(32'hC, TO - 1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      cu_step(a);
      if ($urandom_range(0, 2) == 0) begin
        STALL = 1'b1;
        repeat ($urandom_range(1, 4)) tick;
        chk("stall_req", 32'(MEM_REQ), 32'd0);
        chk("stall_busy", 32'(BUSY), 32'd0);
      end
      w = $urandom_range(0, 5);
      fetch(a, w, $urandom_range(0, 1) == 1);
    end
    // timeout
    do_reset;
    PC_ADDR = 32'h40; PC_CLK = 1'b1;
    tick;
    n = 0;
    while (MEM_REQ && n <= TO + 2) begin
      chk("to_err_low", 32'(FETCH_ERR), 32'd0);
      tick;
      n++;
    end
    chk("to_req_cycles", 32'(n), 32'(TO));
    chk("to_err", 32'(FETCH_ERR), 32'd1);
    chk("to_busy", 32'(BUSY), 32'd0);
    chk("to_enb", 32'(INST_ENB), 32'd0);
    for (int i = 0; i < 6; i++) begin
      PC_CLK = i[0];
      MEM_ACK = 1'b1;
      tick;
      chk("err_req", 32'(MEM_REQ), 32'd0);
      chk("err_sticky", 32'(FETCH_ERR), 32'd1);
    end
    MEM_ACK = 1'b0;
    do_reset;
    // misaligned PC
    PC_ADDR = 32'h6; PC_CLK = 1'b1;
    tick;
    chk("mis_err", 32'(FETCH_ERR), 32'd1);
    chk("mis_req", 32'(MEM_REQ), 32'd0);
    chk("mis_adr", MEM_ADR, 32'd0);
    chk("mis_busy", 32'(BUSY), 32'd0);
    do_reset;
    // reset mid-fetch, late ack ignored
    PC_ADDR = 32'h10; PC_CLK = 1'b1;
    tick;
    repeat (2) tick;
    chk("mid_req", 32'(MEM_REQ), 32'd1);
    RST = 1'b1; PC_CLK = 1'b0;
    tick;
    RST = 1'b0;
    chk("mid_req_off", 32'(MEM_REQ), 32'd0);
    chk("mid_enb", 32'(INST_ENB), 32'd0);
    chk("mid_inst", MEM_INST, NOP);
    chk("mid_cnt", FETCH_CNT, 32'd0);
    MEM_ACK = 1'b1; MEM_RDATA = 32'hDEAD_BEEF;
    tick;
    MEM_ACK = 1'b0;
    tick;
    chk("late_enb", 32'(INST_ENB), 32'd0);
    chk("late_inst", MEM_INST, NOP);
    chk("late_cnt", FETCH_CNT, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
